// File: rtl/unified_mem_arbiter.sv
// Round-robin arbiter sharing one single-ported, variable-latency memory between
// instruction fetch (IF) and load/store (DM), with per-requester stalls and an access timeout.
module unified_mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ack_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ack_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              if_stall_o,
    output logic              dm_stall_o,
    output logic              err_o
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_e            state_q;
    logic              owner_dm_q;
    logic              last_dm_q;
    logic [7:0]        wait_q;
    logic [DATA_W-1:0] if_data_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic              if_ack_q;
    logic              dm_ack_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              err_q;

    logic              grant_dm_d;
    logic              timeout_d;
    logic              busy_end_d;
    logic [DATA_W-1:0] done_data_d;

    // DM wins when alone, or when both request and IF had the previous grant.
    assign grant_dm_d  = dm_req_i & (~if_req_i | ~last_dm_q);
    assign timeout_d   = ~mem_ack_i & (wait_q == WAIT_LAST);
    assign busy_end_d  = mem_ack_i | timeout_d;
    assign done_data_d = mem_ack_i ? mem_rdata_i : '0;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            owner_dm_q  <= 1'b0;
            last_dm_q   <= 1'b0;
            wait_q      <= '0;
            if_data_q   <= '0;
            dm_rdata_q  <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            if_ack_q <= 1'b0;
            dm_ack_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (if_req_i | dm_req_i) begin
                        owner_dm_q <= grant_dm_d;
                        last_dm_q  <= grant_dm_d;
                        wait_q     <= '0;
                        mem_req_q  <= 1'b1;
                        state_q    <= S_BUSY;
                        if (grant_dm_d) begin
                            mem_we_q    <= dm_we_i;
                            mem_addr_q  <= dm_addr_i;
                            mem_wdata_q <= dm_wdata_i;
                        end else begin
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= if_addr_i;
                        end
                    end
                end
                S_BUSY: begin
                    if (!mem_ack_i) wait_q <= wait_q + 8'd1;
                    if (timeout_d) err_q <= 1'b1;
                    if (busy_end_d) begin
                        mem_req_q <= 1'b0;
                        state_q   <= S_DONE;
                        if (owner_dm_q) begin
                            dm_ack_q <= 1'b1;
                            // Stores never disturb the last load result.
                            if (!mem_we_q) dm_rdata_q <= done_data_d;
                        end else begin
                            if_ack_q  <= 1'b1;
                            if_data_q <= done_data_d;
                        end
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign if_data_o   = if_data_q;
    assign if_ack_o    = if_ack_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign dm_ack_o    = dm_ack_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign err_o       = err_q;
    assign if_stall_o  = if_req_i & ~if_ack_q;
    assign dm_stall_o  = dm_req_i & ~dm_ack_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed transaction table, hand-written corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_unified_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        if_req_i, dm_req_i, dm_we_i, mem_ack_i;
    logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i, mem_rdata_i;
    logic [31:0] if_data_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
    logic        if_ack_o, dm_ack_o, mem_req_o, mem_we_o, if_stall_o, dm_stall_o, err_o;

    always #5 clk_i = ~clk_i;

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(15)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ack_o(if_ack_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
        .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
        .if_stall_o(if_stall_o), .dm_stall_o(dm_stall_o), .err_o(err_o)
    );

    typedef struct {
        bit          dm;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] mrdata;
        int          lat;
        logic [31:0] exp_data;
        bit          exp_err;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Memory responder state
    bit          rand_mode = 0;
    int          resp_wait = 0;
    logic [31:0] resp_data = '0;
    bit          stray = 0;
    bit          busy_prev = 0;
    int          cnt = 0;
    bit          acked_last = 0, ack_due = 0, new_busy = 0;
    logic [31:0] cap_addr, cap_wdata;
    logic        cap_we;
    logic [31:0] resp_mem [16];
    logic [31:0] ref_mem  [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Advance to the middle of the next cycle and play the memory side for that cycle.
    task automatic tick();
        @(negedge clk_i);
        ack_due    = acked_last;
        acked_last = 0;
        new_busy   = 0;
        if (mem_req_o) begin
            if (!busy_prev) begin
                new_busy  = 1;
                cap_addr  = mem_addr_o;
                cap_we    = mem_we_o;
                cap_wdata = mem_wdata_o;
                cnt = rand_mode ? int'($urandom_range(0, 4)) : resp_wait;
            end
            if (cnt == 0) begin
                mem_ack_i  = 1'b1;
                acked_last = 1;
                if (rand_mode) begin
                    if (mem_we_o) begin
                        mem_rdata_i = $urandom;
                        resp_mem[mem_addr_o[5:2]] = mem_wdata_o;
                    end else begin
                        mem_rdata_i = resp_mem[mem_addr_o[5:2]];
                    end
                end else begin
                    mem_rdata_i = resp_data;
                end
            end else begin
                mem_ack_i = 1'b0;
                cnt--;
            end
        end else begin
            mem_ack_i   = stray;
            mem_rdata_i = 32'hBAD0_0BAD;
        end
        busy_prev = mem_req_o;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat = 0;
        bit got = 0;
        resp_wait = v.waits;
        resp_data = v.mrdata;
        if (v.dm) begin
            dm_req_i = 1; dm_we_i = v.we; dm_addr_i = v.addr; dm_wdata_i = v.wdata;
        end else begin
            if_req_i = 1; if_addr_i = v.addr;
        end
        #1;
        chk($sformatf("v%0d_stall_c0", idx), v.dm ? dm_stall_o : if_stall_o, 1);
        while (!got && lat < 40) begin
            tick();
            lat++;
            if (new_busy) begin
                chk($sformatf("v%0d_mem_addr", idx), cap_addr, v.addr);
                chk($sformatf("v%0d_mem_we", idx), cap_we, v.we);
                if (v.we) chk($sformatf("v%0d_mem_wdata", idx), cap_wdata, v.wdata);
            end
            got = v.dm ? dm_ack_o : if_ack_o;
            if (v.dm ? if_ack_o : dm_ack_o) chk($sformatf("v%0d_other_ack", idx), 1, 0);
        end
        chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.lat));
        chk($sformatf("v%0d_data", idx), v.dm ? dm_rdata_o : if_data_o, v.exp_data);
        chk($sformatf("v%0d_err", idx), err_o, v.exp_err);
        #1;
        chk($sformatf("v%0d_stall_ack", idx), v.dm ? dm_stall_o : if_stall_o, 0);
        if_req_i = 0; dm_req_i = 0;
        tick();
        chk($sformatf("v%0d_ack_pulse", idx), v.dm ? dm_ack_o : if_ack_o, 0);
    endtask

    vec_t vecs [7];

    initial begin
        int lat;
        int n;
        bit m_last, m_owner, exp_ifa, exp_dma;
        bit p_if, p_dm;
        logic [31:0] exp_ifd, exp_dmd;

        vecs[0] = '{0, 0, 32'h0000_0040, 32'h0, 0, 32'h8C22_0004, 2, 32'h8C22_0004, 0};
        vecs[1] = '{1, 0, 32'h0000_0100, 32'h0, 1, 32'h1234_5678, 3, 32'h1234_5678, 0};
        vecs[2] = '{1, 1, 32'h0000_0020, 32'hCAFE_F00D, 3, 32'hDEAD_BEEF, 5, 32'h1234_5678, 0};
        vecs[3] = '{0, 0, 32'h0000_0044, 32'h0, 2, 32'hA5A5_0001, 4, 32'hA5A5_0001, 0};
        vecs[4] = '{1, 0, 32'h0000_0104, 32'h0, 0, 32'h0000_0000, 2, 32'h0000_0000, 0};
        vecs[5] = '{0, 0, 32'h0000_0080, 32'h0, 255, 32'h5A5A_5A5A, 16, 32'h0000_0000, 1};
        vecs[6] = '{1, 0, 32'h0000_0108, 32'h0, 1, 32'h0BAD_F00D, 3, 32'h0BAD_F00D, 1};

        if_req_i = 0; dm_req_i = 0; dm_we_i = 0; mem_ack_i = 0;
        if_addr_i = '0; dm_addr_i = '0; dm_wdata_i = '0; mem_rdata_i = '0;
        rst_i = 1;
        #2 rst_i = 0;
        #1;
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_if_ack", if_ack_o, 0);
        chk("rst_dm_ack", dm_ack_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_if_data", if_data_o, 0);
        chk("rst_dm_rdata", dm_rdata_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_we", mem_we_o, 0);
        repeat (2) @(negedge clk_i);
        rst_i = 1;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Reset during the second BUSY cycle of a fetch
        resp_wait = 10;
        if_req_i = 1; if_addr_i = 32'h300;
        tick();
        chk("r5_busy1", mem_req_o, 1);
        tick();
        chk("r5_busy2", mem_req_o, 1);
        rst_i = 0;
        #1;
        chk("r5_mem_req", mem_req_o, 0);
        chk("r5_if_ack", if_ack_o, 0);
        chk("r5_dm_ack", dm_ack_o, 0);
        chk("r5_err", err_o, 0);
        chk("r5_if_data", if_data_o, 0);
        rst_i = 1;
        busy_prev = 0; acked_last = 0;
        resp_wait = 0; resp_data = 32'h7777_1111;
        lat = 0;
        do begin tick(); lat++; end while (!if_ack_o && lat < 20);
        chk("r5_regrant_lat", 32'(lat), 2);
        chk("r5_regrant_data", if_data_o, 32'h7777_1111);
        if_req_i = 0;
        tick();
        stray = 1;
        repeat (3) begin
            tick();
            chk("r5_stray_ack", {if_ack_o, dm_ack_o, mem_req_o}, 0);
        end
        stray = 0;
        tick();

        // Simultaneous requests with IF holding the last grant
        resp_wait = 0; resp_data = 32'h5555_AAAA;
        if_req_i = 1; if_addr_i = 32'h200;
        dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h100;
        lat = 0;
        do begin
            tick(); lat++;
            if (if_ack_o) chk("t2_if_first", if_ack_o, 0);
        end while (!dm_ack_o && lat < 20);
        chk("t2_dm_lat", 32'(lat), 2);
        chk("t2_dm_data", dm_rdata_o, 32'h5555_AAAA);
        dm_req_i = 0;
        resp_data = 32'h6666_BBBB;
        lat = 0;
        do begin tick(); lat++; end while (!if_ack_o && lat < 20);
        chk("t2_if_after_dm", 32'(lat), 3);
        chk("t2_if_data", if_data_o, 32'h6666_BBBB);
        if_req_i = 0;
        tick();

        // Both hold requests for six back-to-back transactions
        resp_wait = 1;
        if_req_i = 1; if_addr_i = 32'h200;
        dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h100;
        n = 0; lat = 0;
        while (n < 6 && lat < 100) begin
            tick(); lat++;
            if (new_busy) chk($sformatf("t6_addr%0d", n), cap_addr, (n % 2 == 0) ? 32'h100 : 32'h200);
            if (if_ack_o || dm_ack_o) begin
                chk($sformatf("t6_order%0d", n), {if_ack_o, dm_ack_o}, (n % 2 == 0) ? 2'b01 : 2'b10);
                n++;
            end
        end
        chk("t6_count", 32'(n), 6);
        if_req_i = 0; dm_req_i = 0;
        repeat (2) tick();

        // Randomized traffic against the transaction-level model
        rst_i = 0;
        #1 rst_i = 1;
        busy_prev = 0; acked_last = 0;
        rand_mode = 1;
        for (int i = 0; i < 16; i++) begin
            resp_mem[i] = $urandom;
            ref_mem[i]  = resp_mem[i];
        end
        m_last = 0; m_owner = 0; exp_ifd = '0; exp_dmd = '0; p_if = 0; p_dm = 0;
        for (int c = 0; c < 1500; c++) begin
            tick();
            if (new_busy) begin
                m_owner = (p_if && p_dm) ? !m_last : p_dm;
                m_last  = m_owner;
                chk("rnd_grant_addr", cap_addr, m_owner ? dm_addr_i : if_addr_i);
                chk("rnd_grant_we", cap_we, m_owner ? dm_we_i : 1'b0);
                if (m_owner && dm_we_i) chk("rnd_grant_wdata", cap_wdata, dm_wdata_i);
            end
            exp_ifa = ack_due && !m_owner;
            exp_dma = ack_due && m_owner;
            chk("rnd_if_ack", if_ack_o, exp_ifa);
            chk("rnd_dm_ack", dm_ack_o, exp_dma);
            if (exp_ifa) exp_ifd = ref_mem[if_addr_i[5:2]];
            if (exp_dma) begin
                if (dm_we_i) ref_mem[dm_addr_i[5:2]] = dm_wdata_i;
                else exp_dmd = ref_mem[dm_addr_i[5:2]];
            end
            chk("rnd_if_data", if_data_o, exp_ifd);
            chk("rnd_dm_rdata", dm_rdata_o, exp_dmd);
            if (exp_ifa) if_req_i = 0;
            if (exp_dma) dm_req_i = 0;
            if (!if_req_i && $urandom_range(0, 2) == 0) begin
                if_req_i = 1; if_addr_i = 32'($urandom_range(0, 15)) << 2;
            end
            if (!dm_req_i && $urandom_range(0, 2) == 0) begin
                dm_req_i = 1; dm_we_i = 1'($urandom_range(0, 1));
                dm_addr_i = 32'($urandom_range(0, 15)) << 2; dm_wdata_i = $urandom;
            end
            #1;
            chk("rnd_if_stall", if_stall_o, if_req_i & ~exp_ifa);
            chk("rnd_dm_stall", dm_stall_o, dm_req_i & ~exp_dma);
            p_if = if_req_i;
            p_dm = dm_req_i;
        end
        if_req_i = 0; dm_req_i = 0;
        repeat (10) tick();
        chk("rnd_err", err_o, 0);
        chk("rnd_idle", mem_req_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
